// File: rtl/exe_hazard_ctrl.sv
// EXE-stage hazard controller: load-use and HI/LO stalls, registered forwarding
// selects for the EXE operand muxes, and the MDU busy/countdown sequencer.
module exe_hazard_ctrl #(
  parameter int                 ALUOP_W = 6,
  parameter int                 MUL_LAT = 4,
  parameter int                 DIV_LAT = 32,
  parameter logic [ALUOP_W-1:0] OP_MULT = 6'h18,
  parameter logic [ALUOP_W-1:0] OP_MFHI = 6'h10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_ID_valid,
  input  logic [4:0]         i_ID_rs,
  input  logic [4:0]         i_ID_rt,
  input  logic               i_ID_useRs,
  input  logic               i_ID_useRt,
  input  logic [ALUOP_W-1:0] i_ID_ALUop,
  input  logic [4:0]         i_EXE_WRA,
  input  logic               i_EXE_regWe,
  input  logic               i_EXE_isLoad,
  input  logic [4:0]         i_MEM_WRA,
  input  logic               i_MEM_regWe,
  output logic               o_stallIF,
  output logic               o_stallID,
  output logic               o_flushEXE,
  output logic [1:0]         o_fwdA,
  output logic [1:0]         o_fwdB,
  output logic               o_mduStart,
  output logic               o_mduBusy,
  output logic               o_mduDone
);

  localparam logic [ALUOP_W-1:0] OP_MULTU = ALUOP_W'(OP_MULT + 1);
  localparam logic [ALUOP_W-1:0] OP_DIV   = ALUOP_W'(OP_MULT + 2);
  localparam logic [ALUOP_W-1:0] OP_DIVU  = ALUOP_W'(OP_MULT + 3);
  localparam logic [ALUOP_W-1:0] OP_MFLO  = ALUOP_W'(OP_MFHI + 2);

  localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic       mdu_op, is_div, hilo_op;
  logic       rs_hit_load, rt_hit_load, load_use, mdu_hazard;
  logic       stall, accept;
  logic [1:0] fwd_a_nxt, fwd_b_nxt;

  always_comb begin
    is_div  = (i_ID_ALUop == OP_DIV) || (i_ID_ALUop == OP_DIVU);
    mdu_op  = is_div || (i_ID_ALUop == OP_MULT) || (i_ID_ALUop == OP_MULTU);
    hilo_op = mdu_op || (i_ID_ALUop == OP_MFHI) || (i_ID_ALUop == OP_MFLO);
  end

  // Register 0 never matches because the EXE destination is required nonzero.
  always_comb begin
    rs_hit_load = i_ID_useRs && (i_ID_rs == i_EXE_WRA);
    rt_hit_load = i_ID_useRt && (i_ID_rt == i_EXE_WRA);
    load_use    = i_ID_valid && i_EXE_isLoad && i_EXE_regWe && (i_EXE_WRA != 5'd0)
                  && (rs_hit_load || rt_hit_load);
    mdu_hazard  = i_ID_valid && hilo_op && (state == RUN);
    stall       = load_use || mdu_hazard;
    accept      = i_ID_valid && !stall;
  end

  assign o_stallIF  = stall && !rst;
  assign o_stallID  = stall && !rst;
  assign o_flushEXE = stall && !rst;
  assign o_mduBusy  = (state == RUN);
  assign o_mduDone  = (state == RUN) && (cnt == '0) && !rst;

  // The EXE-stage producer is newer than the MEM-stage one, so it wins.
  always_comb begin
    fwd_a_nxt = 2'b00;
    fwd_b_nxt = 2'b00;
    if (accept) begin
      if (i_ID_useRs && (i_ID_rs != 5'd0)) begin
        if (i_EXE_regWe && (i_ID_rs == i_EXE_WRA))      fwd_a_nxt = 2'b01;
        else if (i_MEM_regWe && (i_ID_rs == i_MEM_WRA)) fwd_a_nxt = 2'b10;
      end
      if (i_ID_useRt && (i_ID_rt != 5'd0)) begin
        if (i_EXE_regWe && (i_ID_rt == i_EXE_WRA))      fwd_b_nxt = 2'b01;
        else if (i_MEM_regWe && (i_ID_rt == i_MEM_WRA)) fwd_b_nxt = 2'b10;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept && mdu_op) begin
          state_nxt = RUN;
          cnt_nxt   = is_div ? DIV_CNT : MUL_CNT;
        end
      end
      RUN: begin
        if (cnt != '0) cnt_nxt = cnt - 1'b1;
        else           state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      o_fwdA     <= 2'b00;
      o_fwdB     <= 2'b00;
      o_mduStart <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      o_fwdA     <= fwd_a_nxt;
      o_fwdB     <= fwd_b_nxt;
      o_mduStart <= accept && mdu_op;
    end
  end

endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// Scoreboard bench for exe_hazard_ctrl: registered selects/start are queued per edge,
// combinational stall/busy/done are checked against per-cycle expectations.
module tb_exe_hazard_ctrl;

  localparam int ALUOP_W = 6;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;

  localparam logic [5:0] OP_ADDU  = 6'h21;
  localparam logic [5:0] OP_MULT  = 6'h18;
  localparam logic [5:0] OP_DIV   = 6'h1A;
  localparam logic [5:0] OP_MFHI  = 6'h10;
  localparam logic [5:0] OP_MFLO  = 6'h12;

  logic clk = 1'b0;
  logic rst;
  logic i_ID_valid, i_ID_useRs, i_ID_useRt;
  logic [4:0] i_ID_rs, i_ID_rt;
  logic [ALUOP_W-1:0] i_ID_ALUop;
  logic [4:0] i_EXE_WRA, i_MEM_WRA;
  logic i_EXE_regWe, i_EXE_isLoad, i_MEM_regWe;
  logic o_stallIF, o_stallID, o_flushEXE;
  logic [1:0] o_fwdA, o_fwdB;
  logic o_mduStart, o_mduBusy, o_mduDone;

  int n_checks = 0;
  int n_pass   = 0;

  // Each entry: {fwdA, fwdB, mduStart} expected after the next posedge.
  logic [4:0] exp_q[$];
  logic [4:0] exp_v;

  always #5 clk = ~clk;

  exe_hazard_ctrl #(
    .ALUOP_W(ALUOP_W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT),
    .OP_MULT(6'h18), .OP_MFHI(6'h10)
  ) dut (
    .clk(clk), .rst(rst),
    .i_ID_valid(i_ID_valid), .i_ID_rs(i_ID_rs), .i_ID_rt(i_ID_rt),
    .i_ID_useRs(i_ID_useRs), .i_ID_useRt(i_ID_useRt), .i_ID_ALUop(i_ID_ALUop),
    .i_EXE_WRA(i_EXE_WRA), .i_EXE_regWe(i_EXE_regWe), .i_EXE_isLoad(i_EXE_isLoad),
    .i_MEM_WRA(i_MEM_WRA), .i_MEM_regWe(i_MEM_regWe),
    .o_stallIF(o_stallIF), .o_stallID(o_stallID), .o_flushEXE(o_flushEXE),
    .o_fwdA(o_fwdA), .o_fwdB(o_fwdB),
    .o_mduStart(o_mduStart), .o_mduBusy(o_mduBusy), .o_mduDone(o_mduDone)
  );

  task automatic set_id(input logic v, input logic [5:0] op,
                        input logic [4:0] rs, input logic urs,
                        input logic [4:0] rt, input logic urt);
    i_ID_valid = v;  i_ID_ALUop = op;
    i_ID_rs = rs;    i_ID_useRs = urs;
    i_ID_rt = rt;    i_ID_useRt = urt;
  endtask

  task automatic set_exe(input logic [4:0] wra, input logic we, input logic ld);
    i_EXE_WRA = wra; i_EXE_regWe = we; i_EXE_isLoad = ld;
  endtask

  task automatic set_mem(input logic [4:0] wra, input logic we);
    i_MEM_WRA = wra; i_MEM_regWe = we;
  endtask

  task automatic clear_all();
    set_id(1'b0, OP_ADDU, 5'd0, 1'b0, 5'd0, 1'b0);
    set_exe(5'd0, 1'b0, 1'b0);
    set_mem(5'd0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_id(1'b1, OP_DIV, 5'd5, 1'b1, 5'd0, 1'b0);
    set_exe(5'd5, 1'b1, 1'b1);
    set_mem(5'd5, 1'b1);
    @(posedge clk); #1;
    n_checks++;
    if (o_stallIF !== 1'b0 || o_stallID !== 1'b0 || o_flushEXE !== 1'b0)
      $display("[TB] FAIL reset_stall: got %b%b%b want 000", o_stallIF, o_stallID, o_flushEXE);
    else n_pass++;
    n_checks++;
    if ({o_fwdA, o_fwdB, o_mduStart, o_mduBusy, o_mduDone} !== 7'b0)
      $display("[TB] FAIL reset_regs: got %b want 0000000",
               {o_fwdA, o_fwdB, o_mduStart, o_mduBusy, o_mduDone});
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_all();
  endtask

  task automatic test_load_use();
    set_exe(5'd5, 1'b1, 1'b1);
    set_mem(5'd0, 1'b0);
    set_id(1'b1, OP_ADDU, 5'd5, 1'b1, 5'd6, 1'b1);
    #1;
    n_checks++;
    if (o_stallIF !== 1'b1 || o_stallID !== 1'b1 || o_flushEXE !== 1'b1)
      $display("[TB] FAIL loaduse_stall: got %b%b%b want 111", o_stallIF, o_stallID, o_flushEXE);
    else n_pass++;
    exp_q.push_back({2'b00, 2'b00, 1'b0});
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    n_checks++;
    if ({o_fwdA, o_fwdB, o_mduStart} !== exp_v)
      $display("[TB] FAIL loaduse_bubble: got %b want %b", {o_fwdA, o_fwdB, o_mduStart}, exp_v);
    else n_pass++;
    // The load has moved to MEM and a bubble sits in EXE.
    set_exe(5'd0, 1'b0, 1'b0);
    set_mem(5'd5, 1'b1);
    #1;
    n_checks++;
    if (o_stallID !== 1'b0)
      $display("[TB] FAIL loaduse_release: got %b want 0", o_stallID);
    else n_pass++;
    exp_q.push_back({2'b10, 2'b00, 1'b0});
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    n_checks++;
    if ({o_fwdA, o_fwdB, o_mduStart} !== exp_v)
      $display("[TB] FAIL loaduse_fwd: got %b want %b", {o_fwdA, o_fwdB, o_mduStart}, exp_v);
    else n_pass++;
    clear_all();
  endtask

  task automatic test_fwd_priority();
    logic [4:0] pat [4][6];
    logic [4:0] want [4];
    // {exeWRA, memWRA, rs, useRs, rt, useRt}
    pat[0] = '{5'd7, 5'd7, 5'd3, 5'd1, 5'd7, 5'd1}; want[0] = {2'b00, 2'b01, 1'b0};
    pat[1] = '{5'd0, 5'd0, 5'd0, 5'd1, 5'd0, 5'd1}; want[1] = {2'b00, 2'b00, 1'b0};
    pat[2] = '{5'd9, 5'd4, 5'd4, 5'd1, 5'd9, 5'd1}; want[2] = {2'b10, 2'b01, 1'b0};
    pat[3] = '{5'd7, 5'd8, 5'd7, 5'd0, 5'd8, 5'd0}; want[3] = {2'b00, 2'b00, 1'b0};
    for (int i = 0; i < 4; i++) begin
      set_exe(pat[i][0], 1'b1, 1'b0);
      set_mem(pat[i][1], 1'b1);
      set_id(1'b1, OP_ADDU, pat[i][2], pat[i][3][0], pat[i][4], pat[i][5][0]);
      exp_q.push_back(want[i]);
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      n_checks++;
      if ({o_fwdA, o_fwdB, o_mduStart} !== exp_v)
        $display("[TB] FAIL fwd_pat%0d: got %b want %b", i, {o_fwdA, o_fwdB, o_mduStart}, exp_v);
      else n_pass++;
    end
    clear_all();
  endtask

  task automatic test_div();
    set_id(1'b1, OP_DIV, 5'd2, 1'b1, 5'd3, 1'b1);
    exp_q.push_back({2'b00, 2'b00, 1'b1});
    @(posedge clk); #1;
    set_id(1'b1, OP_MFLO, 5'd0, 1'b0, 5'd0, 1'b0);
    for (int k = 1; k <= DIV_LAT; k++) begin
      exp_v = exp_q.pop_front();
      n_checks++;
      if ({o_fwdA, o_fwdB, o_mduStart} !== exp_v)
        $display("[TB] FAIL div_regs_c%0d: got %b want %b", k, {o_fwdA, o_fwdB, o_mduStart}, exp_v);
      else n_pass++;
      #1;
      n_checks++;
      if (o_mduBusy !== 1'b1 || o_mduDone !== (k == DIV_LAT) || o_stallID !== 1'b1)
        $display("[TB] FAIL div_c%0d: busy/done/stall got %b%b%b want 1%b1", k,
                 o_mduBusy, o_mduDone, o_stallID, (k == DIV_LAT));
      else n_pass++;
      exp_q.push_back({2'b00, 2'b00, 1'b0});
      @(posedge clk); #1;
    end
    exp_v = exp_q.pop_front();
    n_checks++;
    if ({o_fwdA, o_fwdB, o_mduStart} !== exp_v)
      $display("[TB] FAIL div_last_regs: got %b want %b", {o_fwdA, o_fwdB, o_mduStart}, exp_v);
    else n_pass++;
    n_checks++;
    if (o_mduBusy !== 1'b0 || o_mduDone !== 1'b0 || o_stallID !== 1'b0)
      $display("[TB] FAIL div_mflo_release: busy/done/stall got %b%b%b want 000",
               o_mduBusy, o_mduDone, o_stallID);
    else n_pass++;
    exp_q.push_back({2'b00, 2'b00, 1'b0});
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    n_checks++;
    if ({o_fwdA, o_fwdB, o_mduStart, o_mduBusy} !== {exp_v, 1'b0})
      $display("[TB] FAIL div_mflo_accept: got %b want %b",
               {o_fwdA, o_fwdB, o_mduStart, o_mduBusy}, {exp_v, 1'b0});
    else n_pass++;
    clear_all();
  endtask

  task automatic test_mult_indep();
    logic [4:0] wants [6];
    logic       stall_w [6];
    logic       done_w [6];
    // Cycle 0 MULT accepted, 1 addu with EXE forward, 2..4 second MULT stalled, 5 accepted.
    wants = '{5'b00_00_1, 5'b01_00_0, 5'b0, 5'b0, 5'b0, 5'b00_00_1};
    stall_w = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    done_w  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int c = 0; c < 6; c++) begin
      if (c == 1) begin
        set_exe(5'd2, 1'b1, 1'b0);
        set_id(1'b1, OP_ADDU, 5'd2, 1'b1, 5'd0, 1'b0);
      end else begin
        set_exe(5'd0, 1'b0, 1'b0);
        set_id(1'b1, OP_MULT, 5'd8, 1'b1, 5'd9, 1'b1);
      end
      #1;
      n_checks++;
      if (o_stallID !== stall_w[c] || o_mduDone !== done_w[c] || o_mduBusy !== (c >= 1 && c <= 4))
        $display("[TB] FAIL mult_c%0d: stall/done/busy got %b%b%b want %b%b%b", c,
                 o_stallID, o_mduDone, o_mduBusy, stall_w[c], done_w[c], (c >= 1 && c <= 4));
      else n_pass++;
      exp_q.push_back(wants[c]);
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      n_checks++;
      if ({o_fwdA, o_fwdB, o_mduStart} !== exp_v)
        $display("[TB] FAIL mult_regs_c%0d: got %b want %b", c, {o_fwdA, o_fwdB, o_mduStart}, exp_v);
      else n_pass++;
    end
    clear_all();
    repeat (MUL_LAT) @(posedge clk);
    #1;
    n_checks++;
    if (o_mduBusy !== 1'b0)
      $display("[TB] FAIL mult2_finish: busy got %b want 0", o_mduBusy);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    set_exe(5'd5, 1'b1, 1'b1);
    set_id(1'b1, OP_MULT, 5'd5, 1'b1, 5'd0, 1'b0);
    #1;
    n_checks++;
    if (o_stallID !== 1'b1)
      $display("[TB] FAIL lu_mdu_stall: got %b want 1", o_stallID);
    else n_pass++;
    exp_q.push_back({2'b00, 2'b00, 1'b0});
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    n_checks++;
    if ({o_fwdA, o_fwdB, o_mduStart, o_mduBusy} !== {exp_v, 1'b0})
      $display("[TB] FAIL lu_mdu_nostart: got %b want %b",
               {o_fwdA, o_fwdB, o_mduStart, o_mduBusy}, {exp_v, 1'b0});
    else n_pass++;
    set_exe(5'd0, 1'b0, 1'b0);
    set_mem(5'd5, 1'b1);
    exp_q.push_back({2'b10, 2'b00, 1'b1});
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    n_checks++;
    if ({o_fwdA, o_fwdB, o_mduStart, o_mduBusy} !== {exp_v, 1'b1})
      $display("[TB] FAIL lu_mdu_retry: got %b want %b",
               {o_fwdA, o_fwdB, o_mduStart, o_mduBusy}, {exp_v, 1'b1});
    else n_pass++;
    clear_all();
    repeat (MUL_LAT) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_run();
    set_id(1'b1, OP_DIV, 5'd0, 1'b0, 5'd0, 1'b0);
    exp_q.push_back({2'b00, 2'b00, 1'b1});
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    n_checks++;
    if ({o_fwdA, o_fwdB, o_mduStart} !== exp_v)
      $display("[TB] FAIL rstrun_start: got %b want %b", {o_fwdA, o_fwdB, o_mduStart}, exp_v);
    else n_pass++;
    clear_all();
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    set_exe(5'd3, 1'b1, 1'b1);
    set_id(1'b1, OP_MFHI, 5'd3, 1'b1, 5'd0, 1'b0);
    #1;
    n_checks++;
    if (o_mduBusy !== 1'b1 || o_mduDone !== 1'b0 || o_stallID !== 1'b0)
      $display("[TB] FAIL rstrun_c10: busy/done/stall got %b%b%b want 100",
               o_mduBusy, o_mduDone, o_stallID);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({o_fwdA, o_fwdB, o_mduStart, o_mduBusy, o_mduDone} !== 7'b0)
      $display("[TB] FAIL rstrun_after: got %b want 0000000",
               {o_fwdA, o_fwdB, o_mduStart, o_mduBusy, o_mduDone});
    else n_pass++;
    rst = 1'b0;
    set_exe(5'd3, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (o_stallID !== 1'b0)
      $display("[TB] FAIL rstrun_mfhi_stall: got %b want 0", o_stallID);
    else n_pass++;
    exp_q.push_back({2'b01, 2'b00, 1'b0});
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    n_checks++;
    if ({o_fwdA, o_fwdB, o_mduStart, o_mduBusy} !== {exp_v, 1'b0})
      $display("[TB] FAIL rstrun_mfhi_accept: got %b want %b",
               {o_fwdA, o_fwdB, o_mduStart, o_mduBusy}, {exp_v, 1'b0});
    else n_pass++;
    clear_all();
  endtask

  task automatic test_invalid();
    set_exe(5'd5, 1'b1, 1'b1);
    set_mem(5'd6, 1'b1);
    set_id(1'b0, OP_DIV, 5'd5, 1'b1, 5'd6, 1'b1);
    #1;
    n_checks++;
    if (o_stallIF !== 1'b0 || o_stallID !== 1'b0 || o_flushEXE !== 1'b0)
      $display("[TB] FAIL invalid_stall: got %b%b%b want 000", o_stallIF, o_stallID, o_flushEXE);
    else n_pass++;
    exp_q.push_back({2'b00, 2'b00, 1'b0});
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    n_checks++;
    if ({o_fwdA, o_fwdB, o_mduStart, o_mduBusy} !== {exp_v, 1'b0})
      $display("[TB] FAIL invalid_regs: got %b want %b",
               {o_fwdA, o_fwdB, o_mduStart, o_mduBusy}, {exp_v, 1'b0});
    else n_pass++;
    clear_all();
  endtask

  initial begin
    rst = 1'b1;
    clear_all();
    test_reset();
    test_load_use();
    test_fwd_priority();
    test_div();
    test_mult_indep();
    test_back_to_back();
    test_reset_mid_run();
    test_invalid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
